trace_word_serializer: RTL and testbench

FPGA-side serializer that feeds the trace input of the stream trace buffer. It accepts whole `TRB_WIDTH`-bit words over a ready/valid handshake, double-buffers them, and emits them LSB-first as beats of `2**NUM_TRACES_I` parallel trace bits. Its output connects directly to `FPGA_TRACE_I`/`FPGA_TRACE_VALID_I`/`FPGA_TRACE_READY_O`. It runs entirely in the FPGA clock domain.

---
 rtl/DTB_PKG.sv | 19 +
 rtl/trace_lane_select.sv | 36 +++
 rtl/trace_word_serializer.sv | 133 +++++++++++++
 tb/tb_trace_word_serializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/DTB_PKG.sv
// rtl/DTB_PKG.sv - shared trace buffer constants and serializer state type
package DTB_PKG;

    localparam int TRB_WIDTH      = 32;
    localparam int TRB_MAX_TRACES = 8;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // log2 of the lane count actually used: requests beyond the physical
    // lane count fall back to all lanes.
    function automatic logic [2:0] clamp_lanes_log2(input logic [2:0] num_traces,
                                                    input logic [2:0] max_log2);
        return (num_traces > max_log2) ? max_log2 : num_traces;
    endfunction

endpackage

// File: rtl/trace_lane_select.sv
// rtl/trace_lane_select.sv - combinational beat extraction and lane masking
//
// Ports:
//   word       - word currently being shifted out
//   beat_idx   - beat number within the word
//   lanes_log2 - log2 of active lane count L latched for this word
//   active     - a beat is being presented; output is all-zero otherwise
//   trace      - beat data: trace[j] = word[beat_idx*L + j] for j < L, else 0
module trace_lane_select #(
    parameter int WIDTH      = 32,
    parameter int MAX_TRACES = 8,
    parameter int BEAT_W     = 5
) (
    input  logic [WIDTH-1:0]      word,
    input  logic [BEAT_W-1:0]     beat_idx,
    input  logic [2:0]            lanes_log2,
    input  logic                  active,
    output logic [MAX_TRACES-1:0] trace
);

    logic [BEAT_W-1:0] bit_offset;
    logic [WIDTH-1:0]  shifted;

    always_comb begin
        // beat_idx*L never reaches WIDTH, so the offset fits in BEAT_W bits
        bit_offset = beat_idx << lanes_log2;
        shifted    = word >> bit_offset;
        trace      = '0;
        for (int j = 0; j < MAX_TRACES; j++) begin
            if (active && (j < (1 << lanes_log2))) begin
                trace[j] = shifted[j];
            end
        end
    end

endmodule

// File: rtl/trace_word_serializer.sv
// rtl/trace_word_serializer.sv - double-buffered word to trace-beat serializer
//
// Optional feature macro: STB_SER_UNDERRUN_EN (underrun cycle counter).
//
// Ports:
//   CLK_I          - FPGA clock
//   RST_NI         - asynchronous active-low reset
//   NUM_TRACES_I   - log2 of active lanes, clamped to MAX_TRACES, latched per word
//   WORD_VALID_I   - input word valid
//   WORD_READY_O   - hold buffer empty
//   WORD_I         - input word
//   TRACE_VALID_O  - beat valid
//   TRACE_READY_I  - downstream accepts the beat
//   TRACE_O        - beat data, LSB-first, zero on unused lanes and when idle
//   BUSY_O         - a word is held or being shifted
//   UNDERRUN_CNT_O - saturating count of ready-without-valid cycles after first load
module trace_word_serializer
    import DTB_PKG::*;
#(
    parameter int WIDTH      = TRB_WIDTH,
    parameter int MAX_TRACES = TRB_MAX_TRACES
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic [2:0]            NUM_TRACES_I,
    input  logic                  WORD_VALID_I,
    output logic                  WORD_READY_O,
    input  logic [WIDTH-1:0]      WORD_I,
    output logic                  TRACE_VALID_O,
    input  logic                  TRACE_READY_I,
    output logic [MAX_TRACES-1:0] TRACE_O,
    output logic                  BUSY_O,
    output logic [15:0]           UNDERRUN_CNT_O
);

    localparam int               BEAT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0]       MAX_LOG2 = 3'($clog2(MAX_TRACES));
    localparam logic [BEAT_W:0]  WIDTH_V  = (BEAT_W + 1)'(WIDTH);
    localparam logic [BEAT_W:0]  ONE_V    = (BEAT_W + 1)'(1);

    // HOLD stage
    logic [WIDTH-1:0]  hold_word;
    logic              hold_full;

    // SHIFT stage
    ser_state_t        state;
    logic [WIDTH-1:0]  shift_word;
    logic [BEAT_W-1:0] beat_idx;
    logic [2:0]        lanes_log2;

    logic [BEAT_W:0]   beats_per_word;
    logic              word_fire;
    logic              beat_fire;
    logic              last_fire;
    logic              load;

    assign beats_per_word = WIDTH_V >> lanes_log2;
    assign word_fire      = WORD_VALID_I & ~hold_full;
    assign beat_fire      = (state == SER_SHIFT) & TRACE_READY_I;
    assign last_fire      = beat_fire & ({1'b0, beat_idx} == (beats_per_word - ONE_V));
    // Loading on the last accepted beat is what keeps back-to-back words bubble-free.
    assign load           = hold_full & ((state == SER_IDLE) | last_fire);

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            hold_word  <= '0;
            hold_full  <= 1'b0;
            state      <= SER_IDLE;
            shift_word <= '0;
            beat_idx   <= '0;
            lanes_log2 <= '0;
        end else begin
            if (word_fire) begin
                hold_word <= WORD_I;
            end
            hold_full <= word_fire | (hold_full & ~load);

            if (load) begin
                shift_word <= hold_word;
                beat_idx   <= '0;
                lanes_log2 <= clamp_lanes_log2(NUM_TRACES_I, MAX_LOG2);
                state      <= SER_SHIFT;
            end else if (last_fire) begin
                state      <= SER_IDLE;
            end else if (beat_fire) begin
                beat_idx   <= beat_idx + BEAT_W'(1);
            end
        end
    end

    // Ready is a pure function of registered state, so there is no
    // combinational path from TRACE_READY_I.
    assign WORD_READY_O  = ~hold_full;
    assign TRACE_VALID_O = (state == SER_SHIFT);
    assign BUSY_O        = hold_full | (state == SER_SHIFT);

    trace_lane_select #(
        .WIDTH      (WIDTH),
        .MAX_TRACES (MAX_TRACES),
        .BEAT_W     (BEAT_W)
    ) u_lane_select (
        .word       (shift_word),
        .beat_idx   (beat_idx),
        .lanes_log2 (lanes_log2),
        .active     (TRACE_VALID_O),
        .trace      (TRACE_O)
    );

`ifdef STB_SER_UNDERRUN_EN
    logic        started;
    logic [15:0] underrun_cnt;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            started      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (load) begin
                started <= 1'b1;
            end
            if (started && TRACE_READY_I && (state != SER_SHIFT) &&
                (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

    assign UNDERRUN_CNT_O = underrun_cnt;
`else
    assign UNDERRUN_CNT_O = 16'h0000;
`endif

endmodule

// File: tb/tb_trace_word_serializer.sv
// tb/tb_trace_word_serializer.sv - randomized self-checking bench for trace_word_serializer
module tb_trace_word_serializer;

    localparam int W  = 32;
    localparam int MT = 8;

    logic          CLK_I = 1'b0;
    logic          RST_NI;
    logic [2:0]    NUM_TRACES_I;
    logic          WORD_VALID_I;
    logic          WORD_READY_O;
    logic [W-1:0]  WORD_I;
    logic          TRACE_VALID_O;
    logic          TRACE_READY_I;
    logic [MT-1:0] TRACE_O;
    logic          BUSY_O;
    logic [15:0]   UNDERRUN_CNT_O;

    int n_vec = 0;
    int n_err = 0;

    logic [MT-1:0] exp_q[$];
    logic [15:0]   m_underrun;
    logic          m_arm, m_pend, m_started;
    logic          wa, ba;
    logic [7:0]    t1_beats [4] = '{8'h10, 8'h32, 8'h54, 8'h76};
    logic [MT-1:0] held;
    int            idx, vcnt, first_v, last_v, seen, saw_nr;

    trace_word_serializer #(.WIDTH(W), .MAX_TRACES(MT)) dut (
        .CLK_I          (CLK_I),
        .RST_NI         (RST_NI),
        .NUM_TRACES_I   (NUM_TRACES_I),
        .WORD_VALID_I   (WORD_VALID_I),
        .WORD_READY_O   (WORD_READY_O),
        .WORD_I         (WORD_I),
        .TRACE_VALID_O  (TRACE_VALID_O),
        .TRACE_READY_I  (TRACE_READY_I),
        .TRACE_O        (TRACE_O),
        .BUSY_O         (BUSY_O),
        .UNDERRUN_CNT_O (UNDERRUN_CNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lanes(input logic [2:0] nt);
        return (nt > 3'd3) ? MT : (1 << nt);
    endfunction

    // Reference: a word becomes W/L beats, beat k carrying bits k*L .. k*L+L-1.
    task automatic push_word(input logic [31:0] w, input logic [2:0] nt);
        int l;
        logic [MT-1:0] b;
        l = lanes(nt);
        for (int k = 0; k < W / l; k++) begin
            b = '0;
            for (int j = 0; j < l; j++) b[j] = w[k * l + j];
            exp_q.push_back(b);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_underrun = '0;
        m_arm = 1'b0;
        m_pend = 1'b0;
        m_started = 1'b0;
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input logic wv, input logic [31:0] w, input logic tr,
                        output logic w_acc, output logic b_acc);
        if (TRACE_VALID_O) begin
            if (exp_q.size() == 0) chk("spurious_beat", 32'(TRACE_VALID_O), 32'd0);
            else                   chk("beat_data", 32'(TRACE_O), 32'(exp_q[0]));
        end else begin
            chk("idle_trace_zero", 32'(TRACE_O), 32'd0);
        end
        chk("busy", 32'(BUSY_O), 32'(exp_q.size() != 0));
        chk("underrun_cnt", 32'(UNDERRUN_CNT_O), 32'(m_underrun));
        if (m_pend) m_started = 1'b1;
        if (m_arm)  m_pend = 1'b1;
`ifdef STB_SER_UNDERRUN_EN
        if (m_started && tr && !TRACE_VALID_O && m_underrun != 16'hFFFF) m_underrun++;
`endif
        WORD_VALID_I  = wv;
        WORD_I        = w;
        TRACE_READY_I = tr;
        w_acc = wv & WORD_READY_O;
        b_acc = TRACE_VALID_O & tr;
        if (b_acc) void'(exp_q.pop_front());
        if (w_acc) begin
            push_word(w, NUM_TRACES_I);
            m_arm = 1'b1;
        end
        @(posedge CLK_I);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) step(1'b0, 32'd0, 1'b1, wa, ba);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        step(1'b0, 32'd0, 1'b1, wa, ba);
    endtask

    initial begin
        RST_NI = 1'b0;
        NUM_TRACES_I = 3'd3;
        WORD_VALID_I = 1'b0;
        WORD_I = '0;
        TRACE_READY_I = 1'b0;
        model_reset();
        @(posedge CLK_I);
        @(posedge CLK_I);
        #1;
        chk("rst_word_ready", 32'(WORD_READY_O), 32'd1);
        chk("rst_trace_valid", 32'(TRACE_VALID_O), 32'd0);
        chk("rst_trace", 32'(TRACE_O), 32'd0);
        chk("rst_busy", 32'(BUSY_O), 32'd0);
        chk("rst_underrun", 32'(UNDERRUN_CNT_O), 32'd0);
        RST_NI = 1'b1;
        @(posedge CLK_I);
        #1;

        // 8 lanes: 4 beats, first valid one edge after the accept
        NUM_TRACES_I = 3'd3;
        step(1'b1, 32'h76543210, 1'b1, wa, ba);
        chk("t1_accept", 32'(wa), 32'd1);
        chk("t1_latency_valid", 32'(TRACE_VALID_O), 32'd0);
        chk("t1_hold_not_ready", 32'(WORD_READY_O), 32'd0);
        step(1'b0, 32'd0, 1'b1, wa, ba);
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", 32'(TRACE_VALID_O), 32'd1);
            chk("t1_beat", 32'(TRACE_O), 32'(t1_beats[k]));
            step(1'b0, 32'd0, 1'b1, wa, ba);
        end
        chk("t1_done", 32'(TRACE_VALID_O), 32'd0);

        // 1 lane: 32 beats, only lane 0 ever driven
        NUM_TRACES_I = 3'd0;
        step(1'b1, 32'h00000005, 1'b1, wa, ba);
        step(1'b0, 32'd0, 1'b1, wa, ba);
        for (int k = 0; k < 32; k++) begin
            chk("t2_valid", 32'(TRACE_VALID_O), 32'd1);
            chk("t2_beat", 32'(TRACE_O), (k == 0 || k == 2) ? 32'd1 : 32'd0);
            step(1'b0, 32'd0, 1'b1, wa, ba);
        end
        chk("t2_done", 32'(TRACE_VALID_O), 32'd0);

        // Clamp: 7 behaves as 8 lanes
        NUM_TRACES_I = 3'd7;
        step(1'b1, $urandom, 1'b1, wa, ba);
        seen = 0;
        for (int c = 0; c < 40 && !(seen > 0 && !TRACE_VALID_O); c++) begin
            step(1'b0, 32'd0, 1'b1, wa, ba);
            if (TRACE_VALID_O) seen++;
        end
        chk("t3_clamp_beats", 32'(seen), 32'd4);

        // Back-to-back words 0..15 with 8 lanes
        NUM_TRACES_I = 3'd3;
        idx = 0; vcnt = 0; first_v = -1; last_v = -1; saw_nr = 0;
        for (int c = 0; c < 200 && !(vcnt > 0 && !TRACE_VALID_O); c++) begin
            step(idx < 16, 32'(idx), 1'b1, wa, ba);
            if (wa) idx++;
            if (BUSY_O && !WORD_READY_O) saw_nr = 1;
            if (TRACE_VALID_O) begin
                vcnt++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        chk("t4_words", 32'(idx), 32'd16);
        chk("t4_beats", 32'(vcnt), 32'd64);
        chk("t4_contiguous", 32'(last_v - first_v + 1), 32'd64);
        chk("t4_ready_dropped", 32'(saw_nr), 32'd1);

        // Backpressure mid-word: beat held stable for 5 cycles
        step(1'b1, $urandom, 1'b1, wa, ba);
        step(1'b0, 32'd0, 1'b1, wa, ba);
        step(1'b0, 32'd0, 1'b1, wa, ba);
        held = TRACE_O;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 32'd0, 1'b0, wa, ba);
            chk("t5_stall_valid", 32'(TRACE_VALID_O), 32'd1);
            chk("t5_stall_stable", 32'(TRACE_O), 32'(held));
        end
        drain();

        // Upstream stall with ready high: underrun cycles
        for (int c = 0; c < 3; c++) step(1'b0, 32'd0, 1'b1, wa, ba);

        // Asynchronous reset mid-word
        step(1'b1, 32'hA5C3_0F96, 1'b1, wa, ba);
        step(1'b0, 32'd0, 1'b1, wa, ba);
        step(1'b0, 32'd0, 1'b0, wa, ba);
        WORD_VALID_I = 1'b0;
        #2;
        RST_NI = 1'b0;
        #1;
        chk("arst_valid", 32'(TRACE_VALID_O), 32'd0);
        chk("arst_trace", 32'(TRACE_O), 32'd0);
        chk("arst_busy", 32'(BUSY_O), 32'd0);
        chk("arst_ready", 32'(WORD_READY_O), 32'd1);
        chk("arst_underrun", 32'(UNDERRUN_CNT_O), 32'd0);
        model_reset();
        @(posedge CLK_I);
        #1;
        RST_NI = 1'b1;
        @(posedge CLK_I);
        #1;

        // Randomized traffic; lane count changes only when the serializer is empty
        for (int c = 0; c < 600; c++) begin
            if (exp_q.size() == 0 && $urandom_range(0, 3) == 0)
                NUM_TRACES_I = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 9) < 7, wa, ba);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
